// File: rtl/proj1_pkg.sv
// -----------------------------------------------------------------------------
// proj1_pkg
// Definitions shared by the proj1 counter and its upstream scheduler: the
// default count-request width and the scheduler state encoding.
// No ports (package only).
// -----------------------------------------------------------------------------
package proj1_pkg;

  // Width of a count request; the counter's i_num_cnt uses the same width.
  localparam int DATABIT = 7;

  // Scheduler states. S_IDLE waits for work, S_LAUNCH is the single run-pulse
  // cycle, S_WAIT holds until the counter finishes, S_DONE reports completion.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/proj1_sync_fifo.sv
// -----------------------------------------------------------------------------
// proj1_sync_fifo
// Single-clock request FIFO. Pushes are ignored while full and pops are
// ignored while empty, so callers may assert them freely.
// Ports:
//   clk, reset_n      clock and asynchronous active-low reset (flushes FIFO)
//   i_push, i_wdata   write request and data
//   i_pop             read request; o_rdata always shows the head entry
//   o_level           occupancy, 0..DEPTH
//   o_full, o_empty   occupancy flags
// -----------------------------------------------------------------------------
module proj1_sync_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_full,
  output logic                       o_empty
);
  import proj1_pkg::*;

  localparam int PTRBIT = $clog2(DEPTH);
  localparam int LVLBIT = PTRBIT + 1;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PTRBIT-1:0] r_wrPtr;
  logic [PTRBIT-1:0] r_rdPtr;
  logic [LVLBIT-1:0] r_level;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_level == LVLBIT'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rdPtr];

  // Qualified strobes: the FIFO protects itself against overflow/underflow.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage needs no reset; only the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_wdata;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap around the array by
  // plain overflow. The level is kept separately to tell full from empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTRBIT'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTRBIT'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVLBIT'(1);
        2'b01:   r_level <= r_level - LVLBIT'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/proj1_cnt_sched.sv
// -----------------------------------------------------------------------------
// proj1_cnt_sched
// Command scheduler sitting in front of proj1_cnt. Count requests are queued
// in a FIFO and issued to the counter one at a time: a one-cycle o_run pulse
// when the counter is idle, then a wait for the counter's done, then a
// one-cycle o_job_done pulse and a bump of the completed-job counter.
//
// Build option: define PROJ1_SCHED_ZERO_SKIP_EN to retire zero-valued requests
// without launching the counter (they still report o_job_done).
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   i_req_valid, i_req_cnt       request in (valid/ready)
//   o_req_ready                  FIFO not full
//   o_run, o_num_cnt             launch pulse and count to the counter
//   i_cnt_idle, i_cnt_done       counter status back
//   o_busy                       scheduler not in S_IDLE
//   o_job_done, o_job_cnt        completion pulse and wrapping job count
//   o_level                      FIFO occupancy
// -----------------------------------------------------------------------------
module proj1_cnt_sched #(
  parameter int DATABIT = proj1_pkg::DATABIT,
  parameter int DEPTH   = 4,
  parameter int JOBBIT  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_req_valid,
  input  logic [DATABIT-1:0]     i_req_cnt,
  output logic                   o_req_ready,
  output logic                   o_run,
  output logic [DATABIT-1:0]     o_num_cnt,
  input  logic                   i_cnt_idle,
  input  logic                   i_cnt_done,
  output logic                   o_busy,
  output logic                   o_job_done,
  output logic [JOBBIT-1:0]      o_job_cnt,
  output logic [$clog2(DEPTH):0] o_level
);
  import proj1_pkg::*;

  localparam int LVLBIT = $clog2(DEPTH) + 1;

  sched_state_t        r_state;
  sched_state_t        w_nextState;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [DATABIT-1:0]  w_head;
  logic [LVLBIT-1:0]   w_level;
  logic                r_run;
  logic [DATABIT-1:0]  r_numCnt;
  logic                r_jobDone;
  logic [JOBBIT-1:0]   r_jobCnt;

  // The request queue. Pushes go straight in; the FIFO refuses them when
  // full, which is exactly when o_req_ready is low.
  proj1_sync_fifo #(
    .WIDTH (DATABIT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (i_req_valid),
    .i_pop   (w_pop),
    .i_wdata (i_req_cnt),
    .o_rdata (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_req_ready = !w_full;
  assign o_busy      = (r_state != S_IDLE);
  assign o_level     = w_level;
  assign o_run       = r_run;
  assign o_num_cnt   = r_numCnt;
  assign o_job_done  = r_jobDone;
  assign o_job_cnt   = r_jobCnt;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and pop decision. The pop always happens on the same edge the
  // state leaves S_IDLE, so the head value is captured exactly once. A done
  // from the counter outside S_WAIT is simply never looked at.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
`ifdef PROJ1_SCHED_ZERO_SKIP_EN
          if (w_head == '0) begin
            w_pop       = 1'b1;
            w_nextState = S_DONE;
          end else if (i_cnt_idle) begin
            w_pop       = 1'b1;
            w_nextState = S_LAUNCH;
          end
`else
          if (i_cnt_idle) begin
            w_pop       = 1'b1;
            w_nextState = S_LAUNCH;
          end
`endif
        end
      end
      S_LAUNCH: w_nextState = S_WAIT;
      S_WAIT: begin
        if (i_cnt_done) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE:   w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so that the run and
  // job-done pulses line up exactly with the S_LAUNCH and S_DONE cycles.
  // o_num_cnt only changes on a launch, so it stays put through S_WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run     <= 1'b0;
      r_numCnt  <= '0;
      r_jobDone <= 1'b0;
      r_jobCnt  <= '0;
    end else begin
      r_run     <= (w_nextState == S_LAUNCH);
      r_jobDone <= (w_nextState == S_DONE);
      if (w_pop && (w_nextState == S_LAUNCH)) begin
        r_numCnt <= w_head;
      end
      if (w_nextState == S_DONE) begin
        r_jobCnt <= r_jobCnt + JOBBIT'(1);
      end
    end
  end

endmodule

// File: tb/tb_proj1_cnt_sched.sv
// -----------------------------------------------------------------------------
// tb_proj1_cnt_sched
// Scoreboard bench for proj1_cnt_sched with a behavioural counter model.
// Accepted requests are queued as expected launches; a negedge monitor
// matches launches, completions, job count, level and ready against them.
// -----------------------------------------------------------------------------
module tb_proj1_cnt_sched;

  localparam int DATABIT = 7;
  localparam int DEPTH   = 4;
  localparam int JOBBIT  = 8;
  localparam int LVLBIT  = $clog2(DEPTH) + 1;
  localparam int JOBMOD  = 1 << JOBBIT;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               reqValid;
  logic [DATABIT-1:0] reqCnt;
  logic               reqReady;
  logic               run;
  logic [DATABIT-1:0] numCnt;
  logic               cntIdle;
  logic               cntDone;
  logic               busy;
  logic               jobDone;
  logic [JOBBIT-1:0]  jobCnt;
  logic [LVLBIT-1:0]  level;

  logic holdIdle = 1'b0;
  logic cntIdleM = 1'b1;

  int checks = 0;
  int errors = 0;
  int expQ[$];
  int accepted = 0;
  int removed = 0;
  int modelJobs = 0;
  int numRuns = 0;
  int fixedLatency = 0;
  int busyLeft = 0;
  int lastNum = 0;
  int expVal;
  bit expJd;
  bit doneIssued = 1'b0;
  bit runPrev = 1'b0;
  bit inWait = 1'b0;
  bit sawWrap = 1'b0;

  assign cntIdle = cntIdleM && !holdIdle;

  always #5 clk = ~clk;

  proj1_cnt_sched #(
    .DATABIT (DATABIT),
    .DEPTH   (DEPTH),
    .JOBBIT  (JOBBIT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_req_valid (reqValid),
    .i_req_cnt   (reqCnt),
    .o_req_ready (reqReady),
    .o_run       (run),
    .o_num_cnt   (numCnt),
    .i_cnt_idle  (cntIdle),
    .i_cnt_done  (cntDone),
    .o_busy      (busy),
    .o_job_done  (jobDone),
    .o_job_cnt   (jobCnt),
    .o_level     (level)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit v, input int c);
    @(negedge clk);
    reqValid = v;
    reqCnt   = DATABIT'(c);
  endtask

  task automatic waitJobs(input int target, input int budget, input string name);
    int n = 0;
    while (modelJobs < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, int'(modelJobs >= target), 1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"},    reqReady, 1);
    checkOutput({tag, "_run"},      run, 0);
    checkOutput({tag, "_num_cnt"},  numCnt, 0);
    checkOutput({tag, "_busy"},     busy, 0);
    checkOutput({tag, "_job_done"}, jobDone, 0);
    checkOutput({tag, "_job_cnt"},  jobCnt, 0);
    checkOutput({tag, "_level"},    level, 0);
  endtask

  // Every request the DUT accepts becomes an expected launch, in order.
  always @(posedge clk) begin
    if (reset_n && reqValid && reqReady) begin
      expQ.push_back(int'(reqCnt));
      accepted++;
    end
  end

  // Monitor plus counter model. Launches pop the scoreboard; the counter model
  // then stays busy for a few cycles, pulses done once, and the completion
  // pulse is expected on the following cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      cntIdleM   = 1'b1;
      cntDone    = 1'b0;
      busyLeft   = 0;
      doneIssued = 1'b0;
      runPrev    = 1'b0;
      inWait     = 1'b0;
    end else begin
      if (run) begin
        checkOutput("run_width", int'(runPrev), 0);
        numRuns++;
        if (expQ.size() == 0) begin
          checkOutput("run_unexpected", expQ.size(), 1);
        end else begin
          expVal = expQ.pop_front();
          removed++;
          checkOutput("run_num_cnt", int'(numCnt), expVal);
          lastNum = expVal;
        end
        busyLeft = (fixedLatency > 0) ? fixedLatency : int'($urandom_range(1, 6));
        cntIdleM = 1'b0;
        inWait   = 1'b1;
      end else if (inWait) begin
        checkOutput("num_cnt_hold", int'(numCnt), lastNum);
      end

      expJd = doneIssued;
`ifdef PROJ1_SCHED_ZERO_SKIP_EN
      if (jobDone && !doneIssued && expQ.size() > 0 && expQ[0] == 0) begin
        void'(expQ.pop_front());
        removed++;
        expJd = 1'b1;
      end
`endif
      if (expJd || jobDone) begin
        checkOutput("job_done", int'(jobDone), int'(expJd));
        if (expJd) begin
          modelJobs++;
          checkOutput("job_cnt", int'(jobCnt), modelJobs % JOBMOD);
          if (modelJobs % JOBMOD == 0) sawWrap = 1'b1;
        end
      end
      runPrev    = run;
      doneIssued = 1'b0;

      checkOutput("level", int'(level), accepted - removed);
      checkOutput("req_ready", int'(reqReady), int'((accepted - removed) != DEPTH));

      if (cntDone) begin
        cntDone  = 1'b0;
        cntIdleM = 1'b1;
      end else if (!run && busyLeft > 0) begin
        busyLeft--;
        if (busyLeft == 0) begin
          cntDone    = 1'b1;
          doneIssued = 1'b1;
          inWait     = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int runsBefore;
    int jobsBefore;
    int cyc;

    reset_n  = 1'b0;
    reqValid = 1'b0;
    reqCnt   = '0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset_n = 1'b1;

    // Single request of 100: earliest launch two cycles after the push.
    $display("[TB] single request");
    applyStimulus(1, 100);
    applyStimulus(0, 0);
    checkOutput("first_level", int'(level), 1);
    checkOutput("first_run_early", int'(run), 0);
    @(negedge clk);
    checkOutput("first_run", int'(run), 1);
    checkOutput("first_num_cnt", int'(numCnt), 100);
    checkOutput("first_busy", int'(busy), 1);
    waitJobs(1, 50, "first_job_timeout");
    checkOutput("first_job_cnt", int'(jobCnt), 1);

    // Fill the FIFO while the counter claims to be busy.
    $display("[TB] fill while counter held");
    holdIdle = 1'b1;
    applyStimulus(1, 10);
    applyStimulus(1, 20);
    applyStimulus(1, 30);
    applyStimulus(1, 40);
    applyStimulus(1, 50);
    checkOutput("full_level", int'(level), 4);
    checkOutput("full_ready", int'(reqReady), 0);
    @(negedge clk);
    checkOutput("fifth_rejected_level", int'(level), 4);
    // Release the counter with a push pending: pop happens, push is refused.
    holdIdle = 1'b0;
    reqCnt   = DATABIT'(55);
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("push_pop_full_level", int'(level), 3);
    checkOutput("push_pop_full_ready", int'(reqReady), 1);
    waitJobs(5, 200, "burst_jobs_timeout");
    checkOutput("burst_job_cnt", int'(jobCnt), 5);

    // Asynchronous reset while waiting on the counter with 2 queued.
    $display("[TB] reset during wait");
    fixedLatency = 30;
    applyStimulus(1, 11);
    applyStimulus(1, 22);
    applyStimulus(1, 33);
    applyStimulus(0, 0);
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_busy", int'(busy), 1);
    checkOutput("pre_reset_level", int'(level), 2);
    #2;
    reset_n = 1'b0;
    expQ.delete();
    accepted  = 0;
    removed   = 0;
    modelJobs = 0;
    #1;
    checkResetValues("async_reset");
    repeat (3) @(negedge clk);
    reset_n      = 1'b1;
    fixedLatency = 0;
    runsBefore   = numRuns;
    repeat (10) @(negedge clk);
    checkOutput("post_reset_runs", numRuns - runsBefore, 0);
    checkOutput("post_reset_level", int'(level), 0);

    // Zero-valued request.
    $display("[TB] zero request");
    runsBefore = numRuns;
    jobsBefore = modelJobs;
    applyStimulus(1, 0);
    applyStimulus(0, 0);
`ifdef PROJ1_SCHED_ZERO_SKIP_EN
    waitJobs(jobsBefore + 1, 3, "zero_skip_timeout");
    checkOutput("zero_skip_runs", numRuns - runsBefore, 0);
`else
    waitJobs(jobsBefore + 1, 30, "zero_job_timeout");
    checkOutput("zero_runs", numRuns - runsBefore, 1);
`endif

    // Random traffic long enough for the job counter to wrap.
    $display("[TB] random traffic");
    cyc = 0;
    while (modelJobs < 262 && cyc < 10000) begin
      applyStimulus($urandom_range(0, 2) == 0,
                    ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127)));
      cyc++;
    end
    applyStimulus(0, 0);
    checkOutput("random_jobs_reached", int'(modelJobs >= 262), 1);
    cyc = 0;
    while ((accepted != removed || busy) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    checkOutput("drain_level", int'(level), 0);
    checkOutput("drain_busy", int'(busy), 0);
    checkOutput("final_job_cnt", int'(jobCnt), modelJobs % JOBMOD);
    checkOutput("wrap_seen", int'(sawWrap), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
